// File: rtl/intersection_controller.sv
// Four-way intersection sequencer: alternates NS/EW right-of-way through
// LEFT/GREEN/YELLOW/CLEAR, with emergency preemption and pedestrian walk lamps.
module intersection_controller #(
    parameter int LEFT_CYC   = 5,
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int CLEAR_CYC  = 1,
    parameter int CW         = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       emergency,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    output logic [3:0] ns_out,
    output logic [3:0] ew_out,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic [2:0] phase,
    output logic       dir
);

    typedef enum logic [2:0] {
        S_LEFT    = 3'd0,
        S_GREEN   = 3'd1,
        S_YELLOW  = 3'd2,
        S_CLEAR   = 3'd3,
        S_PREEMPT = 3'd4
    } state_e;

    localparam logic [CW-1:0] LEFT_LD   = CW'(LEFT_CYC - 1);
    localparam logic [CW-1:0] GREEN_LD  = CW'(GREEN_CYC - 1);
    localparam logic [CW-1:0] YELLOW_LD = CW'(YELLOW_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LD  = CW'(CLEAR_CYC - 1);

    localparam logic [3:0] HEAD_LEFT   = 4'b1001;
    localparam logic [3:0] HEAD_GREEN  = 4'b0100;
    localparam logic [3:0] HEAD_YELLOW = 4'b0010;
    localparam logic [3:0] HEAD_RED    = 4'b0001;

    state_e        state_q, state_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          resume_q, resume_d;
    logic          forced_q, forced_d;
    logic          pend_ns_q, pend_ns_d;
    logic          pend_ew_q, pend_ew_d;
    logic          walk_on_q, walk_on_d;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q - 1'b1;
        resume_d  = resume_q;
        forced_d  = forced_q;
        pend_ns_d = pend_ns_q | ped_req_ns;
        pend_ew_d = pend_ew_q | ped_req_ew;
        walk_on_d = walk_on_q;

        case (state_q)
            S_LEFT, S_GREEN: begin
                if (emergency) begin
                    state_d  = S_YELLOW;
                    cnt_d    = YELLOW_LD;
                    forced_d = 1'b1;
                end else if (cnt_q == '0) begin
                    if (state_q == S_LEFT) begin
                        state_d   = S_GREEN;
                        cnt_d     = GREEN_LD;
                        walk_on_d = dir_q ? (pend_ew_q | ped_req_ew) : (pend_ns_q | ped_req_ns);
                    end else begin
                        state_d = S_YELLOW;
                        cnt_d   = YELLOW_LD;
                        // A press in the completing cycle survives the clear.
                        if (dir_q) pend_ew_d = ped_req_ew;
                        else       pend_ns_d = ped_req_ns;
                    end
                end
            end
            S_YELLOW: begin
                if (cnt_q == '0) begin
                    // A forced yellow re-serves the interrupted direction afterwards.
                    resume_d = forced_q ? dir_q : ~dir_q;
                    forced_d = 1'b0;
                    if (emergency) begin
                        state_d = S_PREEMPT;
                        cnt_d   = cnt_q;
                    end else begin
                        state_d = S_CLEAR;
                        cnt_d   = CLEAR_LD;
                    end
                end
            end
            S_CLEAR: begin
                if (emergency) begin
                    state_d = S_PREEMPT;
                    cnt_d   = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = S_LEFT;
                    cnt_d   = LEFT_LD;
                    dir_d   = resume_q;
                end
            end
            S_PREEMPT: begin
                cnt_d = cnt_q;
                if (!emergency) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LD;
                end
            end
            default: begin
                state_d = S_LEFT;
                cnt_d   = LEFT_LD;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LEFT;
            dir_q     <= 1'b0;
            cnt_q     <= LEFT_LD;
            resume_q  <= 1'b0;
            forced_q  <= 1'b0;
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            walk_on_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            resume_q  <= resume_d;
            forced_q  <= forced_d;
            pend_ns_q <= pend_ns_d;
            pend_ew_q <= pend_ew_d;
            walk_on_q <= walk_on_d;
        end
    end

    logic [3:0] own_head;

    always_comb begin
        own_head = HEAD_RED;
        case (state_q)
            S_LEFT:   own_head = HEAD_LEFT;
            S_GREEN:  own_head = HEAD_GREEN;
            S_YELLOW: own_head = HEAD_YELLOW;
            default:  own_head = HEAD_RED;
        endcase
        ns_out = dir_q ? HEAD_RED : own_head;
        ew_out = dir_q ? own_head : HEAD_RED;
    end

    assign walk_ns = walk_on_q & (state_q == S_GREEN) & ~dir_q;
    assign walk_ew = walk_on_q & (state_q == S_GREEN) & dir_q;
    assign phase   = state_q;
    assign dir     = dir_q;

endmodule
